// File: rtl/sram_read_arbiter_pkg.sv
// Shared types and default widths for the scene-SRAM read arbiter and its clients.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sram_read_arbiter_pkg;

   // Defaults shared by face-fetch, vertex shader and the arbiter so widths and latency agree
   localparam int SRA_ADDR_W = 20;
   localparam int SRA_DATA_W = 60;
   localparam int SRA_LAT    = 3;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   // Travels alongside each issued read so the returning word can be steered
   typedef struct packed {
      logic valid;
      logic port;
      logic last;
   } rd_tag_t;

endpackage

// File: rtl/sram_read_arbiter_rd_tag_pipe.sv
// Delays the per-read tag so it lines up with the SRAM data return.
// Latency: LAT+1 cycles from i_tag to o_tag (one for the registered strobe, LAT for the SRAM).
// Backpressure: none; shifts every cycle, reset drops every in-flight tag.
module rd_tag_pipe
   import sram_read_arbiter_pkg::*;
#(
   parameter int LAT = SRA_LAT
) (
   input  logic    clk,
   input  logic    srst_n,
   input  rd_tag_t i_tag,
   output rd_tag_t o_tag
);

   rd_tag_t r_stage [LAT+1];

   // Shift tags toward the tail each cycle; reset invalidates every stage
   always_ff @(posedge clk) begin
      if (!srst_n) begin
         for (int i = 0; i <= LAT; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_tag;
         for (int i = 1; i <= LAT; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_tag = r_stage[LAT];

endmodule

// File: rtl/sram_read_arbiter.sv
// Round-robin arbiter sharing the scene-SRAM read port between face-fetch (0) and vertex fetch (1).
// Latency: accept at T -> beat k strobed at T+1+k, response at T+1+k+LAT.
// Backpressure: reqN_ready low while a burst holds the port; responses cannot be stalled.
module sram_read_arbiter
   import sram_read_arbiter_pkg::*;
#(
   parameter int ADDR_W = SRA_ADDR_W,
   parameter int DATA_W = SRA_DATA_W,
   parameter int LAT    = SRA_LAT
) (
   input  logic              clk,
   input  logic              srst_n,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [1:0]        req0_len,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [1:0]        req1_len,
   output logic              req1_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_data,
   output logic              rsp0_last,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_data,
   output logic              rsp1_last,
   output logic              sram_rd,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic [DATA_W-1:0] sram_rdata
);

   state_e            r_state;
   logic [1:0]        r_beats_left;
   logic [ADDR_W-1:0] r_addr;       // address of the next burst beat
   logic              r_port;
   logic              r_last_grant;
   logic              r_sram_rd;
   logic [ADDR_W-1:0] r_sram_addr;

   logic              w_idle;
   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_acc;
   logic              w_acc_port;
   logic [ADDR_W-1:0] w_acc_addr;
   logic [1:0]        w_acc_len;
   logic              w_iss_vld;
   logic [ADDR_W-1:0] w_iss_addr;
   logic              w_iss_port;
   logic              w_iss_last;
   rd_tag_t           w_push;
   rd_tag_t           w_tail;

   // Arbitration: a lone requester wins, a tie goes to the port that did not win last
   always_comb begin
      w_idle     = (r_state == ST_IDLE);
      w_gnt0     = req0_valid & (~req1_valid | r_last_grant);
      w_gnt1     = req1_valid & (~req0_valid | ~r_last_grant);
      req0_ready = w_idle & w_gnt0;
      req1_ready = w_idle & w_gnt1;
      w_acc      = req0_ready | req1_ready;
      w_acc_port = req1_ready;
      w_acc_addr = req1_ready ? req1_addr : req0_addr;
      w_acc_len  = req1_ready ? req1_len  : req0_len;
   end

   // Beat to issue this cycle: beat 0 straight from the accepted request, later beats from burst state
   always_comb begin
      w_iss_vld  = w_acc | ~w_idle;
      w_iss_addr = w_idle ? w_acc_addr : r_addr;
      w_iss_port = w_idle ? w_acc_port : r_port;
      w_iss_last = w_idle ? (w_acc_len == 2'd0) : (r_beats_left == 2'd1);
   end

   // Burst FSM: hold the port and walk the address (wrapping modulo 2^ADDR_W) until the final beat
   always_ff @(posedge clk) begin
      if (!srst_n) begin
         r_state      <= ST_IDLE;
         r_beats_left <= 2'd0;
         r_addr       <= '0;
         r_port       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_acc && (w_acc_len != 2'd0)) begin
                  r_state      <= ST_BURST;
                  r_beats_left <= w_acc_len;
                  r_addr       <= w_acc_addr + ADDR_W'(1);
                  r_port       <= w_acc_port;
               end
            end
            default: begin
               r_addr       <= r_addr + ADDR_W'(1);
               r_beats_left <= r_beats_left - 2'd1;
               if (r_beats_left == 2'd1) begin
                  r_state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   // Remember the last winner; reset value 1 lets port 0 win the first tie
   always_ff @(posedge clk) begin
      if (!srst_n) begin
         r_last_grant <= 1'b1;
      end else if (w_acc) begin
         r_last_grant <= w_acc_port;
      end
   end

   // Registered SRAM strobe; address holds its last value on idle cycles
   always_ff @(posedge clk) begin
      if (!srst_n) begin
         r_sram_rd   <= 1'b0;
         r_sram_addr <= '0;
      end else begin
         r_sram_rd <= w_iss_vld;
         if (w_iss_vld) begin
            r_sram_addr <= w_iss_addr;
         end
      end
   end

   assign sram_rd   = r_sram_rd;
   assign sram_addr = r_sram_addr;

   assign w_push.valid = w_iss_vld;
   assign w_push.port  = w_iss_port;
   assign w_push.last  = w_iss_last;

   rd_tag_pipe #(
      .LAT (LAT)
   ) u_tag_pipe (
      .clk    (clk),
      .srst_n (srst_n),
      .i_tag  (w_push),
      .o_tag  (w_tail)
   );

   // Steer the returning word by the tag that travelled with its read
   assign rsp0_valid = w_tail.valid & ~w_tail.port;
   assign rsp1_valid = w_tail.valid &  w_tail.port;
   assign rsp0_last  = rsp0_valid & w_tail.last;
   assign rsp1_last  = rsp1_valid & w_tail.last;
   assign rsp0_data  = sram_rdata;
   assign rsp1_data  = sram_rdata;

endmodule
